// File: rtl/mult_div_unit_if.sv
// Handshake/result bundle between the CPU control path and the multiply/divide unit.
// The master drives start/op/operands; the unit returns status and the HI/LO registers.
interface mult_div_unit_if #(
    parameter int data_width = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [data_width-1:0] operand_a;
    logic [data_width-1:0] operand_b;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [data_width-1:0] hi;
    logic [data_width-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: fixed data_width+1 clocks from accepted start to done.
// No queueing: start is only sampled in IDLE; requests while busy are dropped.
module mult_div_unit #(
    parameter int data_width = 32
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);
    localparam int W     = data_width;
    localparam int cnt_w = $clog2(data_width + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [cnt_w-1:0] cnt;
    logic [1:0]       op_q;
    logic             sa;
    logic             sb;
    logic             b_zero;
    logic [W-1:0]     b_mag_q;
    // Multiply: {partial product, remaining multiplier}. Divide: low half is dividend/quotient.
    logic [2*W-1:0]   acc;
    logic [W:0]       rem;

    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic             is_signed;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     quo_fix;
    logic [W-1:0]     rem_fix;

    always_comb begin
        a_neg     = ~bus.op[0] & bus.operand_a[W-1];
        b_neg     = ~bus.op[0] & bus.operand_b[W-1];
        a_mag     = a_neg ? -bus.operand_a : bus.operand_a;
        b_mag     = b_neg ? -bus.operand_b : bus.operand_b;
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, b_mag_q};
        div_shift = {rem[W-1:0], acc[W-1]};
        div_diff  = div_shift - {1'b0, b_mag_q};
        is_signed = ~op_q[0];
        prod      = (is_signed & (sa ^ sb)) ? -acc : acc;
        quo_fix   = (is_signed & (sa ^ sb)) ? -acc[W-1:0] : acc[W-1:0];
        // Remainder follows the dividend's sign; with b == 0 this also restores the raw dividend.
        rem_fix   = (is_signed & sa) ? -rem[W-1:0] : rem[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            op_q            <= '0;
            sa              <= 1'b0;
            sb              <= 1'b0;
            b_zero          <= 1'b0;
            b_mag_q         <= '0;
            acc             <= '0;
            rem             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= CALC;
                        cnt      <= cnt_w'(W);
                        op_q     <= bus.op;
                        sa       <= a_neg;
                        sb       <= b_neg;
                        b_zero   <= (bus.operand_b == '0);
                        b_mag_q  <= b_mag;
                        acc      <= {{W{1'b0}}, a_mag};
                        rem      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == cnt_w'(1)) begin
                        state <= FIX;
                    end
                    if (!op_q[1]) begin
                        acc <= acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
                    end else if (!div_diff[W]) begin
                        rem         <= div_diff;
                        acc[W-1:0]  <= {acc[W-2:0], 1'b1};
                    end else begin
                        rem         <= div_shift;
                        acc[W-1:0]  <= {acc[W-2:0], 1'b0};
                    end
                end
                FIX: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    if (!op_q[1]) begin
                        bus.hi <= prod[2*W-1:W];
                        bus.lo <= prod[W-1:0];
                    end else begin
                        bus.hi          <= rem_fix;
                        bus.lo          <= b_zero ? '1 : quo_fix;
                        bus.div_by_zero <= b_zero;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: result table plus busy-start, done-cycle start and reset-abort sequences.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_unit_if #(.data_width(32)) bus ();
    mult_div_unit #(.data_width(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi = '0;
    vec_t        vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits for done after the start edge; optionally pulses a DIVU 9/3 start at cycle inject_k.
    task automatic wait_done(input string tag, input int inject_k, output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check({tag, " busy in calc"}, 64'(bus.busy), 64'd1);
                check({tag, " hi held in calc"}, 64'(bus.hi), 64'(prev_hi));
            end
            if (k == inject_k) begin
                bus.start = 1'b1; bus.op = OP_DIVU; bus.operand_a = 32'd9; bus.operand_b = 32'd3;
            end
            if (k == inject_k + 1) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        bus.start = 1'b1; bus.op = v.op; bus.operand_a = v.a; bus.operand_b = v.b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op = ~v.op; bus.operand_a = $urandom; bus.operand_b = $urandom;
        wait_done(tag, 0, lat);
        check({tag, " hi"}, 64'(bus.hi), 64'(v.hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(v.lo));
        check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(v.dz));
        check({tag, " busy after"}, 64'(bus.busy), 64'd0);
        prev_hi = v.hi;
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, 64'({bus.done, bus.div_by_zero}), 64'd0);
    endtask

    initial begin
        int lat;
        int done_seen;
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0};
        vecs[5]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{OP_MULTU, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000, 1'b0};
        vecs[10] = '{OP_DIVU,  32'd1000,     32'd7,        32'd6,        32'd142,      1'b0};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset flags", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Start while busy is dropped; a start in the done cycle is accepted.
        bus.start = 1'b1; bus.op = OP_MULTU; bus.operand_a = 32'd6; bus.operand_b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("busy start", 9, lat);
        check("busy start lo", 64'(bus.lo), 64'd42);
        check("busy start hi", 64'(bus.hi), 64'd0);
        prev_hi = '0;
        bus.start = 1'b1; bus.op = OP_MULTU; bus.operand_a = 32'd5; bus.operand_b = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("done-cycle start accepted", 64'(bus.busy), 64'd1);
        wait_done("done-cycle start", 0, lat);
        check("done-cycle start lo", 64'(bus.lo), 64'd45);

        // Reset mid-divide aborts with no done pulse.
        bus.start = 1'b1; bus.op = OP_DIVU; bus.operand_a = 32'd1000; bus.operand_b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort hi", 64'(bus.hi), 64'd0);
        check("abort lo", 64'(bus.lo), 64'd0);
        check("abort busy/done", 64'({bus.busy, bus.done}), 64'd0);
        #2;
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        check("abort no done", 64'(done_seen), 64'd0);
        prev_hi = '0;
        run_vec('{OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0}, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the multicycle CPU, downstream of the register file. It consumes the two register-file read ports (rs and rt) for MULT/MULTU/DIV/DIVU and holds the 64-bit result in internal HI/LO registers. The control FSM stalls on `busy`, then moves HI/LO back into the register file as write data (MFHI/MFLO).

## Interface
- `data_width`, default 32: operand width. The HI/LO product is 2×`data_width`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: request a new operation. Sampled only in IDLE.
- `op` in 2: operation select. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- `operand_a` in `data_width`: rs value (read_data_1), captured on the accepted start.
- `operand_b` in `data_width`: rt value (read_data_2), captured on the accepted start.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse. HI/LO hold the new result in the same cycle.
- `div_by_zero` out 1: pulses with `done` when a DIV/DIVU had `operand_b` == 0.
- `hi` out `data_width`: HI register. Holds the product upper half or the remainder.
- `lo` out `data_width`: LO register. Holds the product lower half or the quotient.

## Operation
- FSM states and transitions:
  - IDLE → CALC on `start`.
  - CALC stays for `data_width` iterations; a counter loads `data_width` and decrements to 0.
  - CALC → FIX when the counter reaches 0.
  - FIX → IDLE unconditionally.
- On an accepted start:
  - Latch `op`.
  - For signed ops, latch |a| and |b| and the sign bits sa and sb.
  - For unsigned ops, latch the raw operands.
- Multiply:
  - Shift-add over a 2×`data_width` accumulator, one multiplier bit per CALC cycle.
  - FIX negates the 64-bit magnitude (two's complement) when the op is signed and sa^sb = 1.
- Divide:
  - Restoring division, one quotient bit per CALC cycle, with a `data_width`+1-bit partial remainder.
  - FIX negates the quotient when signed and sa^sb = 1.
  - FIX negates the remainder when signed and sa = 1, so the remainder takes the dividend's sign.
- Divide by zero, both DIV and DIVU, same latency as a normal op: HI = `operand_a` (raw), LO = all ones, `div_by_zero` = 1.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, no flag.
- HI/LO update only at the FIX→IDLE edge and keep their previous values during CALC.
- `start` while busy (CALC/FIX) is ignored and not queued.
- `op` and operand changes after acceptance have no effect.

## Timing
- Reset values, applied asynchronously on `rst`:
  - State = IDLE.
  - `hi` = `lo` = 0.
  - `busy` = `done` = `div_by_zero` = 0.
  - Counter = 0.
- Reset mid-operation aborts the op; HI/LO are cleared to 0 and no `done` is issued.
- Edge numbering: `start` is sampled high at edge E0. CALC iterations occur at E1..E32, and FIX completes at E33.
- `busy` is 1 from after E0 until E33, and 0 after E33.
- `done` and `div_by_zero` are 1 for exactly the cycle between E33 and E34.
- Total latency is 33 clocks from the start edge to the result, fixed for all ops and operands. There is no early termination.
- A `start` in the cycle where `done` = 1 is accepted at E34 (state is IDLE). Back-to-back throughput is one op per 34 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- MULTU, a = 0xFFFFFFFF, b = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `done` high exactly 33 edges after the start edge; `busy` low afterwards.
- MULT, a = 0xFFFFFFFD (−3), b = 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. Then MULT, a = 0x80000000, b = 0x80000000 → HI = 0x40000000, LO = 0.
- DIV, a = 0xFFFFFFF9 (−7), b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then DIVU, a = 0xFFFFFFF9, b = 2 → LO = 0x7FFFFFFC, HI = 1.
- DIVU, a = 100, b = 0 → HI = 100, LO = 0xFFFFFFFF, `div_by_zero` = 1 with `done`. Then DIV, a = 0x80000000, b = 0xFFFFFFFF → LO = 0x80000000, HI = 0, `div_by_zero` = 0.
- Start MULTU 6×7, pulse `start` with DIVU 9/3 at edge E10 → only 6×7 completes (LO = 42, HI = 0) at E33. A `start` held in the `done` cycle is accepted, and its result arrives 33 edges later.
- Start DIVU 1000/7, assert `rst` between E15 and E16 → `hi`, `lo`, `busy`, and `done` go to 0 immediately. No `done` pulse occurs. A following MULTU 3×4 gives LO = 12.
